// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin scheduler that owns the select of a 16:1 single-bit mux
// and presents the selected requester's bit to one consumer over valid/ready.
// A grant lasts until its requester drops req or until MAX_BURST beats are accepted.
// After a release, the search restarts just past the old grantee, so the old grantee
// has the lowest priority.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req       - per-requester request bits
//   data_in   - mux data inputs, data_in[i] belongs to requester i
//   out_ready - consumer accepts a beat this cycle
//   out_valid - out_data carries a valid beat (req[sel] while granted)
//   out_data  - mux output, data_in[sel]
//   sel       - registered mux select
//   gnt       - registered one-hot grant, all zero when idle
//   busy      - high while a grant is held
module mux16_rr_sched #(
    parameter int unsigned N         = 16,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     data_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_data,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     gnt,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [3:0] LastBeat = 4'(MAX_BURST - 1);

    state_e           state;
    logic [SEL_W-1:0] ptr;
    logic [3:0]       beat_cnt;

    // First requester at or after start, wrapping; returns start if none is pending.
    function automatic logic [SEL_W-1:0] search(input logic [N-1:0]     r,
                                                input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] idx;
        search = start;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (r[idx]) begin
                search = idx;
            end
        end
    endfunction

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic             granted;
    logic             req_sel;
    logic             any_req;
    logic             xfer;
    logic             rel;
    logic [SEL_W-1:0] sel_inc;
    logic [SEL_W-1:0] pick_idle;
    logic [SEL_W-1:0] pick_rel;

    always_comb begin
        granted   = (state == StGrant);
        req_sel   = req[sel];
        any_req   = |req;
        xfer      = granted & req_sel & out_ready;
        rel       = granted & (~req_sel | (xfer & (beat_cnt == LastBeat)));
        sel_inc   = sel + SEL_W'(1);
        pick_idle = search(req, ptr);
        pick_rel  = search(req, sel_inc);
    end

    // The 16:1 mux itself: data_in indexed by the registered select.
    assign out_data  = data_in[sel];
    assign out_valid = granted & req_sel;
    assign busy      = granted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            sel      <= '0;
            gnt      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        state    <= StGrant;
                        sel      <= pick_idle;
                        gnt      <= onehot(pick_idle);
                        beat_cnt <= '0;
                    end
                end
                StGrant: begin
                    if (rel) begin
                        ptr <= sel_inc;
                        // Re-arbitrate on the release edge so consecutive grants have no bubble.
                        if (any_req) begin
                            sel      <= pick_rel;
                            gnt      <= onehot(pick_rel);
                            beat_cnt <= '0;
                        end else begin
                            state    <= StIdle;
                            gnt      <= '0;
                            beat_cnt <= '0;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
